// File: rtl/mips_dmem_responder.sv
// Purpose : memory-side responder for the MIPS core data port, backed by an internal word array.
// Latency : rsp_valid rises LATENCY cycles after request acceptance, for good and error requests alike.
// Backpress: rsp_ready=0 holds the response stable indefinitely; no new request is taken until the handshake.
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   req_valid/req_ready            request handshake; req_we, req_addr, req_wdata, req_be sampled at acceptance
//   rsp_valid/rsp_ready            response handshake; rsp_rdata (0 for stores/errors), rsp_err
//   err_count                      saturating count of error responses handed to the core
//   busy                           high whenever a transaction is in flight (BUSY or RESP)
module mips_dmem_responder #(
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2,
  parameter int ADDR_W   = 32,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [3:0]          req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state, stateNext;
  logic [3:0]          cnt, cntNext;

  logic                weQ;
  logic [ADDR_W-1:0]   addrQ;
  logic [31:0]         wdataQ;
  logic [3:0]          beQ;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         rdataQ;
  logic                errQ;
  logic [ERRCNT_W-1:0] errCnt;

  logic                accept;
  logic                access;
  logic                rspFire;
  logic                accWe;
  logic [ADDR_W-1:0]   accAddr;
  logic [31:0]         accWdata;
  logic [3:0]          accBe;
  logic                accErr;
  logic [IDX_W-1:0]    accIdx;

  // Next-state and handshake outputs.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          cntNext   = CNT_LOAD;
          stateNext = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cntNext = cnt - 4'd1;
        if (cnt == 4'd1) stateNext = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign accept  = req_valid && req_ready;
  assign rspFire = rsp_valid && rsp_ready;
  // The access edge is the one that enters RESP.
  assign access  = (stateNext == RESP) && (state != RESP);

  // With single-cycle latency the access edge is the acceptance edge, so the
  // live request fields are used; otherwise the latched copies are.
  always_comb begin
    accWe    = weQ;
    accAddr  = addrQ;
    accWdata = wdataQ;
    accBe    = beQ;
    if (state == IDLE) begin
      accWe    = req_we;
      accAddr  = req_addr;
      accWdata = req_wdata;
      accBe    = req_be;
    end
  end

  // Misaligned, or any address bit above the storage range set.
  assign accErr = (accAddr[1:0] != 2'b00) || ((accAddr >> (IDX_W + 2)) != '0);
  assign accIdx = accAddr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      weQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      beQ    <= '0;
      rdataQ <= '0;
      errQ   <= 1'b0;
      errCnt <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        weQ    <= req_we;
        addrQ  <= req_addr;
        wdataQ <= req_wdata;
        beQ    <= req_be;
      end
      if (access) begin
        errQ   <= accErr;
        rdataQ <= (accErr || accWe) ? 32'd0 : mem[accIdx];
      end
      if (rspFire && errQ && (errCnt != '1)) errCnt <= errCnt + ERRCNT_W'(1);
    end
  end

  // Storage is never cleared; reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && access && accWe && !accErr) begin
      for (int i = 0; i < 4; i++) begin
        if (accBe[i]) mem[accIdx][8*i +: 8] <= accWdata[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = rdataQ;
  assign rsp_err   = errQ;
  assign err_count = errCnt;

endmodule

// File: tb/tb_mips_dmem_responder.sv
module tb_mips_dmem_responder;

  logic        clk;
  logic        rst;
  logic [1:0]  reqValid;
  logic [1:0]  rspReady;
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  reqBe;

  wire  [1:0]  reqReady;
  wire  [1:0]  rspValid;
  wire  [1:0]  rspErr;
  wire  [1:0]  busy;
  wire  [31:0] rspRdata0, rspRdata1;
  wire  [7:0]  errCount0, errCount1;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  // Reference state: word contents and error count per instance.
  logic [31:0] refMem [2][256];
  int          refErr [2];

  mips_dmem_responder #(.DEPTH(256), .LATENCY(2), .ADDR_W(32), .ERRCNT_W(8)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe), .req_addr(reqAddr),
    .req_wdata(reqWdata), .req_be(reqBe),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata0), .rsp_err(rspErr[0]),
    .err_count(errCount0), .busy(busy[0])
  );

  mips_dmem_responder #(.DEPTH(256), .LATENCY(1), .ADDR_W(32), .ERRCNT_W(8)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe), .req_addr(reqAddr),
    .req_wdata(reqWdata), .req_be(reqBe),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata1), .rsp_err(rspErr[1]),
    .err_count(errCount1), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rdataOf(input int s);
    return (s == 0) ? rspRdata0 : rspRdata1;
  endfunction

  function automatic logic [31:0] errCountOf(input int s);
    return (s == 0) ? {24'd0, errCount0} : {24'd0, errCount1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance s, with bp cycles of response back-pressure.
  task automatic txn(input int s, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int bp, output logic [31:0] rd, output int acc);
    bit          expErr;
    logic [31:0] expData;
    int          idx;
    int          k;
    int          expLat;

    expLat  = (s == 0) ? 2 : 1;
    expErr  = (addr % 4 != 0) || (addr >= 32'd1024);
    idx     = int'(addr / 4) % 256;
    expData = (expErr || we) ? 32'd0 : refMem[s][idx];

    reqWe = we; reqAddr = addr; reqWdata = wdata; reqBe = be;
    reqValid[s] = 1'b1;
    rspReady[s] = (bp == 0);
    k = 0;
    while (!reqReady[s] && k < 100) begin @(posedge clk); #1; k++; end
    check("req_ready before accept", {31'd0, reqReady[s]}, 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    reqValid[s] = 1'b0;
    reqWe = 1'($urandom); reqAddr = $urandom; reqWdata = $urandom; reqBe = 4'($urandom);
    if (expLat > 1) check("busy after accept", {31'd0, busy[s]}, 32'd1);
    check("req_ready low after accept", {31'd0, reqReady[s]}, 32'd0);

    k = 0;
    while (!rspValid[s] && k < 100) begin @(posedge clk); #1; k++; end
    check("latency", k + 1, expLat);
    check("rsp_rdata", rdataOf(s), expData);
    check("rsp_err", {31'd0, rspErr[s]}, {31'd0, expErr});
    rd = rdataOf(s);

    for (int i = 0; i < bp; i++) begin
      // Stray requests while not ready must be ignored.
      reqValid[s] = 1'b1; reqWe = 1'b1; reqAddr = 32'($urandom_range(0, 255)) * 4;
      reqWdata = $urandom; reqBe = 4'hF;
      @(posedge clk); #1;
      check("bp rsp_valid held", {31'd0, rspValid[s]}, 32'd1);
      check("bp rsp_rdata held", rdataOf(s), expData);
      check("bp rsp_err held", {31'd0, rspErr[s]}, {31'd0, expErr});
      check("bp req_ready low", {31'd0, reqReady[s]}, 32'd0);
    end
    reqValid[s] = 1'b0;
    rspReady[s] = 1'b1;
    @(posedge clk); #1;

    if (expErr) begin
      if (refErr[s] < 255) refErr[s]++;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) refMem[s][idx][8*b +: 8] = wdata[8*b +: 8];
    end
    check("rsp_valid dropped", {31'd0, rspValid[s]}, 32'd0);
    check("req_ready after handshake", {31'd0, reqReady[s]}, 32'd1);
    check("busy after handshake", {31'd0, busy[s]}, 32'd0);
    check("err_count", errCountOf(s), refErr[s]);
  endtask

  initial begin
    logic [31:0] rd;
    int          acc;
    int          prevAcc;
    logic [31:0] addr;
    int          r;

    rst = 1'b0; reqValid = 2'b00; rspReady = 2'b11;
    reqWe = 1'b0; reqAddr = '0; reqWdata = '0; reqBe = '0;
    refErr[0] = 0; refErr[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      check("reset req_ready", {31'd0, reqReady[s]}, 32'd1);
      check("reset rsp_valid", {31'd0, rspValid[s]}, 32'd0);
      check("reset rsp_err", {31'd0, rspErr[s]}, 32'd0);
      check("reset rsp_rdata", rdataOf(s), 32'd0);
      check("reset err_count", errCountOf(s), 32'd0);
      check("reset busy", {31'd0, busy[s]}, 32'd0);
    end

    // Bring both storage arrays to a known all-zero state.
    for (int i = 0; i < 256; i++) begin
      txn(0, 1'b1, 32'(i * 4), 32'd0, 4'hF, 0, rd, acc);
      txn(1, 1'b1, 32'(i * 4), 32'd0, 4'hF, 0, rd, acc);
    end

    // Store then load, full and partial byte enables.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, acc);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, acc);
    check("load after store", rd, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd, acc);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, acc);
    check("partial store load", rd, 32'hDE22BE44);
    txn(0, 1'b1, 32'h10, 32'h55555555, 4'h0, 0, rd, acc);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, acc);
    check("be=0 store no-op", rd, 32'hDE22BE44);

    // Misaligned and out-of-range requests.
    txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, rd, acc);
    txn(0, 1'b0, 32'h400, 32'h0, 4'h0, 0, rd, acc);
    check("err_count after two errors", errCountOf(0), 32'd2);
    txn(0, 1'b1, 32'h402, 32'hFFFFFFFF, 4'hF, 0, rd, acc);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, acc);
    check("error store left word 0", rd, 32'd0);

    // Back-pressure for five cycles on a load.
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, acc);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, acc);
    check("stray requests ignored", rd, 32'hDE22BE44);

    // Reset while the store to 0x20 is in BUSY.
    reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'hCAFEF00D; reqBe = 4'hF;
    check("ready before reset-store", {31'd0, reqReady[0]}, 32'd1);
    reqValid[0] = 1'b1;
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    check("busy before mid reset", {31'd0, busy[0]}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    refErr[0] = 0; refErr[1] = 0;
    check("rsp_valid after mid reset", {31'd0, rspValid[0]}, 32'd0);
    check("err_count after mid reset", errCountOf(0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rsp_valid stays low", {31'd0, rspValid[0]}, 32'd0);
    end
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, acc);
    check("abandoned store not written", rd, 32'h0);

    // LATENCY=1 back-to-back traffic.
    prevAcc = 0;
    for (int i = 0; i < 8; i++) begin
      txn(1, 1'(i % 2 == 0), 32'(((i / 2) + 5) * 4), $urandom, 4'hF, 0, rd, acc);
      if (i > 0) check("acceptance spacing", acc - prevAcc, 32'd2);
      prevAcc = acc;
    end

    // Random mixed traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else if (r == 1) addr = $urandom;
      else             addr = 32'($urandom_range(0, 255)) * 4;
      txn($urandom_range(0, 1), 1'($urandom), addr, $urandom, 4'($urandom),
          $urandom_range(0, 2), rd, acc);
    end

    // Drive the LATENCY=1 error counter into saturation.
    for (int i = 0; i < 260; i++) txn(1, 1'b0, 32'h3, 32'h0, 4'h0, 0, rd, acc);
    check("err_count saturated", errCountOf(1), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
